// File: rtl/xbar_rr_nxn_if.sv
// Valid/ready bundle for the N x N round-robin crossbar.
// The master side drives the input ports and the output ready, and
// observes the input ready and the output beats. The slave side is the
// switch itself.
interface xbar_rr_nxn_if #(
    parameter int N  = 2,
    parameter int DW = 35
);
    localparam int DESTW = $clog2(N);

    logic [N-1:0]       i_valid;
    logic [N-1:0]       i_ready;
    logic [N*DW-1:0]    i_data;
    logic [N*DESTW-1:0] i_dest;
    logic [N-1:0]       i_last;

    logic [N-1:0]       o_valid;
    logic [N-1:0]       o_ready;
    logic [N*DW-1:0]    o_data;
    logic [N-1:0]       o_last;

    modport master (
        output i_valid, i_data, i_dest, i_last, o_ready,
        input  i_ready, o_valid, o_data, o_last
    );

    modport slave (
        input  i_valid, i_data, i_dest, i_last, o_ready,
        output i_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/xbar_rr_nxn.sv
// N x N valid/ready crossbar switch element.
// Each input names its destination output explicitly. Every output has a
// round-robin arbiter that stays locked to one input for the whole of a
// multi-beat packet, and a 2-entry registered buffer. The buffer head is
// a register, so the outputs carry no combinational path from the inputs,
// and input ready never depends on output ready.
module xbar_rr_nxn #(
    parameter int N  = 2,
    parameter int DW = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    xbar_rr_nxn_if.slave bus
);
    localparam int DESTW = $clog2(N);

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    // Per-output registered state.
    arb_state_t       arb_state [N];
    logic [DESTW-1:0] owner     [N];
    logic [DESTW-1:0] rr_ptr    [N];
    logic [1:0]       cnt       [N];
    beat_t            slot0     [N];   // FIFO head, drives the output
    beat_t            slot1     [N];   // second entry

    // Per-input decode and per-output arbitration results.
    logic [DESTW-1:0] dest      [N];
    logic [N-1:0]     req       [N];   // req[j][i]: input i wants output j
    logic [DESTW-1:0] gnt       [N];
    logic [N-1:0]     gnt_vld;
    logic [N-1:0]     ready;
    logic [N-1:0]     push;
    logic [N-1:0]     pop;
    beat_t            beat      [N];

    logic [N-1:0]     head_valid;
    logic [N*DW-1:0]  head_data;
    logic [N-1:0]     head_last;

    // Split out each destination field and build the request matrix.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            dest[i] = bus.i_dest[i*DESTW +: DESTW];
        end
        for (int unsigned j = 0; j < N; j++) begin
            req[j] = '0;
            for (int unsigned i = 0; i < N; i++) begin
                req[j][i] = bus.i_valid[i] && (dest[i] == DESTW'(j));
            end
        end
    end

    // Per-output grant: locked owner, else first requester from rr_ptr.
    // The scan runs from the farthest offset down so the nearest one wins.
    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            gnt[j]     = owner[j];
            gnt_vld[j] = 1'b0;
            if (arb_state[j] == ARB_LOCKED) begin
                gnt_vld[j] = req[j][owner[j]];
            end else begin
                for (int unsigned k = N; k > 0; k--) begin
                    if (req[j][rr_ptr[j] + DESTW'(k - 1)]) begin
                        gnt[j]     = rr_ptr[j] + DESTW'(k - 1);
                        gnt_vld[j] = 1'b1;
                    end
                end
            end
        end
    end

    // Input ready: granted on its destination and that buffer not full.
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ready[i] = rst_n && gnt_vld[dest[i]]
                       && (gnt[dest[i]] == DESTW'(i))
                       && (cnt[dest[i]] != 2'd2);
        end
    end

    assign bus.i_ready = ready;

    // Per-output push/pop strobes and the beat offered by the granted input.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            push[j]      = gnt_vld[j] && bus.i_valid[gnt[j]] && ready[gnt[j]];
            pop[j]       = (cnt[j] != 2'd0) && bus.o_ready[j];
            beat[j].last = bus.i_last[gnt[j]];
            beat[j].data = bus.i_data[int'(gnt[j])*DW +: DW];
        end
    end

    // Arbiter lock/pointer update and 2-entry shift FIFO per output.
    // A pop shifts slot1 into slot0; a push then lands in the first free
    // slot counted after that shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N; j++) begin
                arb_state[j] <= ARB_OPEN;
                owner[j]     <= '0;
                rr_ptr[j]    <= '0;
                cnt[j]       <= '0;
                slot0[j]     <= '0;
                slot1[j]     <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                if (push[j]) begin
                    if (beat[j].last) begin
                        arb_state[j] <= ARB_OPEN;
                        rr_ptr[j]    <= gnt[j] + DESTW'(1);
                    end else begin
                        arb_state[j] <= ARB_LOCKED;
                        owner[j]     <= gnt[j];
                    end
                end

                if (pop[j]) begin
                    slot0[j] <= slot1[j];
                end
                if (push[j]) begin
                    if ((cnt[j] == 2'd0) || (pop[j] && (cnt[j] == 2'd1))) begin
                        slot0[j] <= beat[j];
                    end else begin
                        slot1[j] <= beat[j];
                    end
                end

                if (push[j] && !pop[j]) begin
                    cnt[j] <= cnt[j] + 2'd1;
                end else if (!push[j] && pop[j]) begin
                    cnt[j] <= cnt[j] - 2'd1;
                end
            end
        end
    end

    // Output view of each FIFO head.
    always_comb begin
        head_valid = '0;
        head_data  = '0;
        head_last  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            head_valid[j]          = (cnt[j] != 2'd0);
            head_data[j*DW +: DW]  = slot0[j].data;
            head_last[j]           = slot0[j].last;
        end
    end

    assign bus.o_valid = head_valid;
    assign bus.o_data  = head_data;
    assign bus.o_last  = head_last;
endmodule

// File: tb/tb_xbar_rr_nxn.sv
// Directed bench for xbar_rr_nxn: one N=2 and one N=4 instance share clock
// and reset. Inputs change 1 time unit after a rising edge; combinational
// ready and registered outputs are sampled 1 unit after that.
module tb_xbar_rr_nxn;
    localparam int DW = 35;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xbar_rr_nxn_if #(.N(2), .DW(DW)) bus2 ();
    xbar_rr_nxn_if #(.N(4), .DW(DW)) bus4 ();

    xbar_rr_nxn #(.N(2), .DW(DW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    xbar_rr_nxn #(.N(4), .DW(DW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input int i, input logic v, input logic [DW-1:0] d,
                          input logic dst, input logic l);
        bus2.i_valid[i]         = v;
        bus2.i_data[i*DW +: DW] = d;
        bus2.i_dest[i]          = dst;
        bus2.i_last[i]          = l;
    endtask

    task automatic drive4(input int i, input logic v, input logic [DW-1:0] d,
                          input logic [1:0] dst, input logic l);
        bus4.i_valid[i]         = v;
        bus4.i_data[i*DW +: DW] = d;
        bus4.i_dest[i*2 +: 2]   = dst;
        bus4.i_last[i]          = l;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (bus2.o_valid !== 2'b00) begin errors++; $display("FAIL reset_o_valid2: got %b expected 00", bus2.o_valid); end
        checks++; if (bus2.o_data !== '0) begin errors++; $display("FAIL reset_o_data2: got %h expected 0", bus2.o_data); end
        checks++; if (bus2.o_last !== 2'b00) begin errors++; $display("FAIL reset_o_last2: got %b expected 00", bus2.o_last); end
        bus2.i_valid = 2'b11;
        bus2.i_dest  = 2'b01;
        #1;
        checks++; if (bus2.i_ready !== 2'b00) begin errors++; $display("FAIL reset_i_ready2: got %b expected 00", bus2.i_ready); end
        checks++; if (bus4.o_valid !== 4'b0000) begin errors++; $display("FAIL reset_o_valid4: got %b expected 0000", bus4.o_valid); end
        bus2.i_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_distinct();
        tick();
        bus2.o_ready = 2'b11;
        drive2(0, 1'b1, 35'hA, 1'b1, 1'b1);
        drive2(1, 1'b1, 35'hB, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b11) begin errors++; $display("FAIL distinct_ready: got %b expected 11", bus2.i_ready); end
        tick();
        bus2.i_valid = '0;
        #1;
        checks++; if (bus2.o_valid !== 2'b11) begin errors++; $display("FAIL distinct_o_valid: got %b expected 11", bus2.o_valid); end
        checks++; if (bus2.o_data[DW +: DW] !== 35'hA) begin errors++; $display("FAIL distinct_o_data1: got %h expected a", bus2.o_data[DW +: DW]); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'hB) begin errors++; $display("FAIL distinct_o_data0: got %h expected b", bus2.o_data[0 +: DW]); end
        checks++; if (bus2.o_last !== 2'b11) begin errors++; $display("FAIL distinct_o_last: got %b expected 11", bus2.o_last); end
        tick();
        checks++; if (bus2.o_valid !== 2'b00) begin errors++; $display("FAIL distinct_drain: got %b expected 00", bus2.o_valid); end
    endtask

    task automatic test_rr_stream();
        int n[2];
        int w;
        logic [1:0]    exp_rdy;
        logic [DW-1:0] exp;
        n[0] = 0; n[1] = 0; w = 0;
        tick();
        bus2.o_ready = 2'b11;
        drive2(0, 1'b1, 35'h100, 1'b0, 1'b1);
        drive2(1, 1'b1, 35'h200, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_rdy = (w == 0) ? 2'b01 : 2'b10;
            checks++; if (bus2.i_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, bus2.i_ready, exp_rdy); end
            exp = DW'(((w == 0) ? 32'h100 : 32'h200) + n[w]);
            tick();
            n[w]++;
            drive2(w, 1'b1, DW'(((w == 0) ? 32'h100 : 32'h200) + n[w]), 1'b0, 1'b1);
            checks++; if (bus2.o_valid[0] !== 1'b1 || bus2.o_data[0 +: DW] !== exp) begin errors++; $display("FAIL rr_out0[%0d]: got v=%b d=%h expected v=1 d=%h", c, bus2.o_valid[0], bus2.o_data[0 +: DW], exp); end
            w = 1 - w;
        end
        bus2.i_valid = '0;
        tick();
        checks++; if (bus2.o_valid[0] !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", bus2.o_valid[0]); end
    endtask

    task automatic test_lock();
        tick();
        bus2.o_ready = 2'b11;
        drive2(1, 1'b1, 35'h10, 1'b0, 1'b0);
        #1;
        checks++; if (bus2.i_ready !== 2'b10) begin errors++; $display("FAIL lock_beat1_ready: got %b expected 10", bus2.i_ready); end
        tick();
        drive2(1, 1'b1, 35'h11, 1'b0, 1'b0);
        drive2(0, 1'b1, 35'h20, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b10) begin errors++; $display("FAIL lock_beat2_ready: got %b expected 10", bus2.i_ready); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h10 || bus2.o_last[0] !== 1'b0) begin errors++; $display("FAIL lock_out_10: got d=%h l=%b expected d=10 l=0", bus2.o_data[0 +: DW], bus2.o_last[0]); end
        tick();
        drive2(1, 1'b1, 35'h12, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b10) begin errors++; $display("FAIL lock_beat3_ready: got %b expected 10", bus2.i_ready); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h11) begin errors++; $display("FAIL lock_out_11: got %h expected 11", bus2.o_data[0 +: DW]); end
        tick();
        drive2(1, 1'b0, 35'h0, 1'b0, 1'b0);
        #1;
        checks++; if (bus2.i_ready !== 2'b01) begin errors++; $display("FAIL lock_release_ready: got %b expected 01", bus2.i_ready); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h12 || bus2.o_last[0] !== 1'b1) begin errors++; $display("FAIL lock_out_12: got d=%h l=%b expected d=12 l=1", bus2.o_data[0 +: DW], bus2.o_last[0]); end
        tick();
        bus2.i_valid = '0;
        #1;
        checks++; if (bus2.o_valid[0] !== 1'b1 || bus2.o_data[0 +: DW] !== 35'h20) begin errors++; $display("FAIL lock_out_in0: got v=%b d=%h expected v=1 d=20", bus2.o_valid[0], bus2.o_data[0 +: DW]); end
        tick();
        checks++; if (bus2.o_valid[0] !== 1'b0) begin errors++; $display("FAIL lock_drain: got %b expected 0", bus2.o_valid[0]); end
    endtask

    task automatic test_backpressure();
        tick();
        bus2.o_ready = 2'b10;
        drive2(0, 1'b1, 35'h1, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_1: got %b expected 1", bus2.i_ready[0]); end
        tick();
        drive2(0, 1'b1, 35'h2, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_2: got %b expected 1", bus2.i_ready[0]); end
        checks++; if (bus2.o_valid[0] !== 1'b1 || bus2.o_data[0 +: DW] !== 35'h1) begin errors++; $display("FAIL bp_head_first: got v=%b d=%h expected v=1 d=1", bus2.o_valid[0], bus2.o_data[0 +: DW]); end
        tick();
        drive2(0, 1'b1, 35'h3, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", bus2.i_ready[0]); end
        tick();
        bus2.o_ready = 2'b11;
        #1;
        checks++; if (bus2.i_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_full_with_oready: got %b expected 0", bus2.i_ready[0]); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h1) begin errors++; $display("FAIL bp_head_held: got %h expected 1", bus2.o_data[0 +: DW]); end
        tick();
        #1;
        checks++; if (bus2.i_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", bus2.i_ready[0]); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h2) begin errors++; $display("FAIL bp_out_2: got %h expected 2", bus2.o_data[0 +: DW]); end
        tick();
        bus2.i_valid = '0;
        #1;
        checks++; if (bus2.o_valid[0] !== 1'b1 || bus2.o_data[0 +: DW] !== 35'h3) begin errors++; $display("FAIL bp_out_3: got v=%b d=%h expected v=1 d=3", bus2.o_valid[0], bus2.o_data[0 +: DW]); end
        tick();
        checks++; if (bus2.o_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus2.o_valid[0]); end
    endtask

    task automatic test_reset_mid_packet();
        tick();
        bus2.o_ready = 2'b00;
        drive2(1, 1'b1, 35'h30, 1'b0, 1'b0);
        #1;
        checks++; if (bus2.i_ready !== 2'b10) begin errors++; $display("FAIL rmp_beat1_ready: got %b expected 10", bus2.i_ready); end
        tick();
        drive2(1, 1'b1, 35'h31, 1'b0, 1'b0);
        tick();
        drive2(1, 1'b1, 35'h32, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b00 || bus2.o_valid[0] !== 1'b1) begin errors++; $display("FAIL rmp_full: got rdy=%b v=%b expected rdy=00 v=1", bus2.i_ready, bus2.o_valid[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus2.o_valid !== 2'b00 || bus2.o_data !== '0) begin errors++; $display("FAIL rmp_async_clear: got v=%b d=%h expected v=00 d=0", bus2.o_valid, bus2.o_data); end
        checks++; if (bus2.i_ready !== 2'b00) begin errors++; $display("FAIL rmp_ready_in_reset: got %b expected 00", bus2.i_ready); end
        bus2.i_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus2.o_valid !== 2'b00) begin errors++; $display("FAIL rmp_after_release: got %b expected 00", bus2.o_valid); end
        bus2.o_ready = 2'b11;
        drive2(0, 1'b1, 35'h40, 1'b0, 1'b1);
        drive2(1, 1'b1, 35'h41, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b01) begin errors++; $display("FAIL rmp_first_contention: got %b expected 01", bus2.i_ready); end
        tick();
        drive2(0, 1'b1, 35'h42, 1'b0, 1'b1);
        #1;
        checks++; if (bus2.i_ready !== 2'b10) begin errors++; $display("FAIL rmp_second_contention: got %b expected 10", bus2.i_ready); end
        checks++; if (bus2.o_data[0 +: DW] !== 35'h40) begin errors++; $display("FAIL rmp_out_40: got %h expected 40", bus2.o_data[0 +: DW]); end
        tick();
        bus2.i_valid = '0;
        #1;
        checks++; if (bus2.o_data[0 +: DW] !== 35'h41) begin errors++; $display("FAIL rmp_out_41: got %h expected 41", bus2.o_data[0 +: DW]); end
        tick();
        checks++; if (bus2.o_valid !== 2'b00) begin errors++; $display("FAIL rmp_drain: got %b expected 00", bus2.o_valid); end
    endtask

    task automatic test_n4_rr();
        int n[4];
        int w;
        logic [3:0]    exp_rdy;
        logic [DW-1:0] exp;
        for (int i = 0; i < 4; i++) n[i] = 0;
        w = 0;
        tick();
        bus4.o_ready = 4'b1111;
        for (int i = 0; i < 4; i++) drive4(i, 1'b1, DW'(32'h300 + i*16), 2'd3, 1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = 4'b0001 << w;
            checks++; if (bus4.i_ready !== exp_rdy) begin errors++; $display("FAIL n4_ready[%0d]: got %b expected %b", c, bus4.i_ready, exp_rdy); end
            exp = DW'(32'h300 + w*16 + n[w]);
            tick();
            n[w]++;
            drive4(w, 1'b1, DW'(32'h300 + w*16 + n[w]), 2'd3, 1'b1);
            checks++; if (bus4.o_valid[3] !== 1'b1 || bus4.o_data[3*DW +: DW] !== exp) begin errors++; $display("FAIL n4_out3[%0d]: got v=%b d=%h expected v=1 d=%h", c, bus4.o_valid[3], bus4.o_data[3*DW +: DW], exp); end
            w = (w + 1) % 4;
        end
        checks++; if (bus4.o_valid[2:0] !== 3'b000) begin errors++; $display("FAIL n4_other_outputs: got %b expected 000", bus4.o_valid[2:0]); end
        bus4.i_valid = '0;
        tick();
        checks++; if (bus4.o_valid !== 4'b0000) begin errors++; $display("FAIL n4_drain: got %b expected 0000", bus4.o_valid); end
    endtask

    initial begin
        bus2.i_valid = '0; bus2.i_data = '0; bus2.i_dest = '0; bus2.i_last = '0; bus2.o_ready = '0;
        bus4.i_valid = '0; bus4.i_data = '0; bus4.i_dest = '0; bus4.i_last = '0; bus4.o_ready = '0;
        test_reset();
        test_distinct();
        test_rr_stream();
        test_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_n4_rr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
